// File: rtl/mjpeg_byte_packer.sv
// Packs encoder bytes into 128-bit frame words behind a first-word-fall-through FIFO.
// Head word is visible one cycle after a push into an empty FIFO; the encoder is never stalled, and drops set o_overflow.

module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 129
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         empty,
    output logic         drop
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         full;
    logic         rd_en;
    logic         wr_en;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en    = pop && !empty;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign wr_en    = push && (!full || rd_en);
    assign drop     = push && !wr_en;
    assign head_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= push_dat;
    end
endmodule

module mjpeg_byte_packer #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [7:0]  PAD_BYTE   = 8'hFF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_de,
    input  logic [7:0]   i_data,
    input  logic         i_done,
    output logic [127:0] o_word,
    output logic         o_last,
    output logic         o_valid,
    input  logic         i_ready,
    output logic         o_frame_done,
    output logic [23:0]  o_byte_cnt,
    output logic         o_overflow,
    output logic         o_busy
);
    typedef enum logic [1:0] {S_IDLE, S_FILL, S_FLUSH, S_DONE} state_t;

    state_t            state;
    logic [3:0]        lane_cnt;
    logic [15:0][7:0]  lane_dat;
    logic [15:0][7:0]  pend_dat;
    logic              pend_vld;
    logic [15:0][7:0]  pad_dat;
    logic [23:0]       frame_cnt;
    logic              accept;
    logic              push;
    logic [128:0]      push_dat;
    logic [128:0]      head_dat;
    logic              fifo_empty;
    logic              fifo_drop;
    logic              pop;

    assign accept  = i_de && (state == S_IDLE || state == S_FILL);
    assign o_valid = !fifo_empty;
    assign pop     = o_valid && i_ready;
    // Gate the head so outputs read zero while the FIFO is empty.
    assign o_word  = o_valid ? head_dat[127:0] : '0;
    assign o_last  = o_valid && head_dat[128];
    assign o_busy  = (state != S_IDLE);

    always_comb begin
        pad_dat = lane_dat;
        for (int i = 0; i < 16; i++) begin
            if (4'(i) >= lane_cnt) pad_dat[i] = PAD_BYTE;
        end
    end

    always_comb begin
        push     = 1'b0;
        push_dat = '0;
        if (state == S_FLUSH) begin
            if (pend_vld) begin
                push     = 1'b1;
                push_dat = {1'b1, pend_dat};
            end else if (lane_cnt != 4'd0) begin
                push     = 1'b1;
                push_dat = {1'b1, pad_dat};
            end
        end else if (accept && pend_vld) begin
            push     = 1'b1;
            push_dat = {1'b0, pend_dat};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            lane_cnt     <= '0;
            lane_dat     <= '0;
            pend_dat     <= '0;
            pend_vld     <= 1'b0;
            frame_cnt    <= '0;
            o_frame_done <= 1'b0;
            o_byte_cnt   <= '0;
            o_overflow   <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            if (fifo_drop || (i_de && (state == S_FLUSH || state == S_DONE)))
                o_overflow <= 1'b1;

            if (accept) begin
                lane_dat[lane_cnt] <= i_data;
                lane_cnt           <= lane_cnt + 4'd1;
                pend_vld           <= (lane_cnt == 4'd15);
                if (lane_cnt == 4'd15) pend_dat <= {i_data, lane_dat[14:0]};
                if (frame_cnt != 24'hFF_FFFF) frame_cnt <= frame_cnt + 24'd1;
            end

            case (state)
                S_IDLE: begin
                    if (i_done)    state <= S_FLUSH;
                    else if (i_de) state <= S_FILL;
                end
                S_FILL: begin
                    if (i_done) state <= S_FLUSH;
                end
                S_FLUSH: begin
                    state        <= S_DONE;
                    lane_cnt     <= '0;
                    pend_vld     <= 1'b0;
                    o_frame_done <= 1'b1;
                    o_byte_cnt   <= frame_cnt;
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    frame_cnt <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    sync_fifo #(.DEPTH(FIFO_DEPTH), .W(129)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head_dat),
        .empty    (fifo_empty),
        .drop     (fifo_drop)
    );
endmodule

// File: tb/tb_mjpeg_byte_packer.sv
// Scoreboard bench: expected frame words and byte counts are queued from a byte-list model, a monitor pops and compares.
`timescale 1ns/1ps
module tb_mjpeg_byte_packer;
    localparam int         DEPTH = 8;
    localparam logic [7:0] PAD   = 8'hFF;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_de;
    logic [7:0]   i_data;
    logic         i_done;
    logic         i_ready;
    logic [127:0] o_word;
    logic         o_last;
    logic         o_valid;
    logic         o_frame_done;
    logic [23:0]  o_byte_cnt;
    logic         o_overflow;
    logic         o_busy;

    int n_tests = 0;
    int n_fail  = 0;
    int ready_mode = 1;
    logic [128:0] exp_q[$];
    int           cnt_q[$];

    always #5 clk = ~clk;

    mjpeg_byte_packer #(.FIFO_DEPTH(DEPTH), .PAD_BYTE(PAD)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_de         (i_de),
        .i_data       (i_data),
        .i_done       (i_done),
        .o_word       (o_word),
        .o_last       (o_last),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_frame_done (o_frame_done),
        .o_byte_cnt   (o_byte_cnt),
        .o_overflow   (o_overflow),
        .o_busy       (o_busy)
    );

    task automatic chk(input string name, input logic [128:0] act, input logic [128:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: frame bytes chopped into 16-byte words, lane 0 in the low byte, tail padded, last flag on the final word.
    function automatic void model_frame(input logic [7:0] b[$], input int keep);
        int n  = b.size();
        int nw = (n + 15) / 16;
        for (int k = 0; k < nw; k++) begin
            logic [128:0] w;
            w = '0;
            for (int j = 0; j < 16; j++)
                w[8*j +: 8] = (16*k + j < n) ? b[16*k + j] : PAD;
            w[128] = (k == nw - 1);
            if (k < keep) exp_q.push_back(w);
        end
        cnt_q.push_back(n);
    endfunction

    task automatic run_frame(input logic [7:0] b[$], input bit done_with_last, input bit gaps,
                             input bit de_in_flush, input int keep);
        model_frame(b, keep);
        foreach (b[i]) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin i_de = 1'b0; tick(); end
            i_de   = 1'b1;
            i_data = b[i];
            i_done = done_with_last && (i == b.size() - 1);
            tick();
        end
        i_de = 1'b0;
        if (!(done_with_last && b.size() > 0)) begin
            i_done = 1'b1;
            tick();
        end
        i_done = 1'b0;
        chk("busy_in_flush", 129'(o_busy), 129'(1));
        if (de_in_flush) begin
            i_de   = 1'b1;
            i_data = 8'h5A;
        end
        tick();
        i_de = 1'b0;
        tick();
        chk("busy_back_idle", 129'(o_busy), 129'(0));
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((exp_q.size() != 0 || cnt_q.size() != 0) && k < 500) begin
            tick();
            k++;
        end
        chk(name, 129'(exp_q.size() + cnt_q.size()), 129'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1; i_de = 1'b0; i_done = 1'b0;
        tick(); tick();
        exp_q.delete();
        cnt_q.delete();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        i_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       i_ready = 1'b0;
                1:       i_ready = 1'b1;
                default: i_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        logic [128:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (o_valid && i_ready) begin
                    chk("word_queued", 129'(exp_q.size() != 0), 129'(1));
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("word", {o_last, o_word}, e);
                    end
                end
                if (o_frame_done) begin
                    chk("frame_done_queued", 129'(cnt_q.size() != 0), 129'(1));
                    if (cnt_q.size() != 0) chk("byte_cnt", 129'(o_byte_cnt), 129'(cnt_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] b[$];
        rst = 1'b1; i_de = 1'b0; i_done = 1'b0; i_data = 8'h00;
        tick(); tick();
        chk("rst_valid",      129'(o_valid),      129'(0));
        chk("rst_word",       129'(o_word),       129'(0));
        chk("rst_last",       129'(o_last),       129'(0));
        chk("rst_frame_done", 129'(o_frame_done), 129'(0));
        chk("rst_byte_cnt",   129'(o_byte_cnt),   129'(0));
        chk("rst_overflow",   129'(o_overflow),   129'(0));
        chk("rst_busy",       129'(o_busy),       129'(0));
        rst = 1'b0;
        tick();

        // 32 bytes, done with the last byte
        b.delete();
        for (int i = 0; i < 32; i++) b.push_back(8'(i));
        run_frame(b, 1'b1, 1'b0, 1'b0, 100);
        drain("drain_32");

        // 20 bytes, done one cycle later
        b.delete();
        for (int i = 0; i < 20; i++) b.push_back(8'(8'hA0 + i));
        run_frame(b, 1'b0, 1'b0, 1'b0, 100);
        drain("drain_20");

        // zero-byte frame
        b.delete();
        run_frame(b, 1'b0, 1'b0, 1'b0, 100);
        drain("drain_empty");
        chk("empty_frame_no_word", 129'(o_valid), 129'(0));
        chk("no_overflow_yet", 129'(o_overflow), 129'(0));

        // byte presented during flush is dropped
        b.delete();
        for (int i = 0; i < 5; i++) b.push_back(8'(8'h30 + i));
        run_frame(b, 1'b0, 1'b0, 1'b1, 100);
        drain("drain_flush_de");
        chk("overflow_flush_de", 129'(o_overflow), 129'(1));
        repeat (5) tick();
        chk("overflow_sticky", 129'(o_overflow), 129'(1));
        do_reset();
        chk("overflow_cleared", 129'(o_overflow), 129'(0));

        // FIFO fill with downstream stalled: only DEPTH words survive
        ready_mode = 0;
        tick(); tick();
        b.delete();
        for (int i = 0; i < 160; i++) b.push_back(8'($urandom));
        run_frame(b, 1'b0, 1'b0, 1'b0, DEPTH);
        chk("overflow_fifo_full", 129'(o_overflow), 129'(1));
        chk("full_valid", 129'(o_valid), 129'(1));
        ready_mode = 1;
        drain("drain_full");
        repeat (4) tick();
        chk("full_drained", 129'(o_valid), 129'(0));
        do_reset();

        // reset mid-frame discards the partial word
        for (int i = 0; i < 7; i++) begin
            i_de = 1'b1; i_data = 8'(8'hE0 + i);
            tick();
        end
        i_de = 1'b0;
        do_reset();
        b.delete();
        for (int i = 0; i < 16; i++) b.push_back(8'(8'h40 + i));
        run_frame(b, 1'b1, 1'b0, 1'b0, 100);
        drain("drain_after_reset");
        chk("overflow_after_reset", 129'(o_overflow), 129'(0));

        // randomized frames with random downstream readiness
        ready_mode = 2;
        repeat (12) begin
            int n;
            n = $urandom_range(0, 48);
            b.delete();
            for (int i = 0; i < n; i++) b.push_back(8'($urandom));
            run_frame(b, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 100);
        end
        ready_mode = 1;
        drain("drain_random");
        chk("overflow_random", 129'(o_overflow), 129'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
